// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared definitions for the cmp magnitude comparator:
//                default operand/counter widths, the slice width used to
//                build the comparison, the enumerated result type and a
//                helper that maps slice-tree outputs onto that type.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_pkg;

    // Default operand width in bits.
    localparam int c_def_width = 8;

    // Default width of each saturating result counter.
    localparam int c_def_cnt_w = 16;

    // Width of one comparator slice; operands are padded to a multiple of it.
    localparam int c_slice_w   = 4;

    // Outcome of one comparison.
    typedef enum logic [1:0] {
        RES_LT = 2'd0,
        RES_EQ = 2'd1,
        RES_GT = 2'd2
    } res_e;

    // Map the (gt, eq) pair from the slice tree onto a single result code.
    // eq dominates so a spurious gt can never coexist with equality.
    function automatic res_e classify(input logic gt, input logic eq);
        if (eq) begin
            return RES_EQ;
        end else if (gt) begin
            return RES_GT;
        end else begin
            return RES_LT;
        end
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_slice.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_slice
//  Description : Purely combinational 4-bit unsigned magnitude comparator.
//                Reports whether the A nibble is greater than, or equal to,
//                the B nibble. "Less than" is implied when neither is set.
//  Ports       : i_a  [3:0] in   first operand nibble
//                i_b  [3:0] in   second operand nibble
//                o_gt       out  i_a > i_b
//                o_eq       out  i_a == i_b
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_slice
    import cmp_pkg::*;
(
    input  logic [c_slice_w-1:0] i_a,
    input  logic [c_slice_w-1:0] i_b,
    output logic                 o_gt,
    output logic                 o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);

endmodule : cmp_slice
`default_nettype wire

// File: rtl/cmp.sv
`default_nettype none
// ============================================================================
//  Module      : cmp
//  Description : Registered WIDTH-bit magnitude comparator with selectable
//                unsigned / two's-complement mode and three saturating
//                result counters. One result per cycle, latency one cycle,
//                no backpressure.
//  Ports       : clk        in   clock, rising-edge active
//                rst_n      in   asynchronous active-low reset
//                a, b       in   WIDTH-bit operands
//                in_valid   in   operands valid this cycle
//                signed_en  in   1 = two's-complement compare, 0 = unsigned
//                cnt_clr    in   synchronous clear of all counters
//                gt/lt/eq   out  registered, one-hot after any valid result
//                out_valid  out  one-cycle pulse marking a new result
//                gt_cnt, lt_cnt, eq_cnt  out  saturating CNT_W-bit counts
//  Revision    : 1.0  initial release
// ============================================================================
module cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             signed_en,
    input  logic             cnt_clr,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             out_valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    // ------------------------------------------------------------------------
    // Padded width and number of slices
    // ------------------------------------------------------------------------
    localparam int c_num_slices = (WIDTH + c_slice_w - 1) / c_slice_w;
    localparam int c_pad_w      = c_num_slices * c_slice_w;

    // Saturating increment: a counter at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Operand conditioning
    // Operands are zero-extended to the padded width. The padding bits are
    // identical in both operands, so they never influence the outcome.
    // For a signed compare, flipping the sign bit of both operands maps
    // two's-complement ordering onto unsigned ordering (offset binary), so
    // the same unsigned slice tree serves both modes. Equality is unchanged
    // by the flip, which keeps eq independent of signed_en.
    // ------------------------------------------------------------------------
    logic [c_pad_w-1:0] w_a_ext;
    logic [c_pad_w-1:0] w_b_ext;

    always_comb begin
        w_a_ext            = '0;
        w_b_ext            = '0;
        w_a_ext[WIDTH-1:0] = a;
        w_b_ext[WIDTH-1:0] = b;
        w_a_ext[WIDTH-1]   = a[WIDTH-1] ^ signed_en;
        w_b_ext[WIDTH-1]   = b[WIDTH-1] ^ signed_en;
    end

    // ------------------------------------------------------------------------
    // Slice array
    // ------------------------------------------------------------------------
    logic [c_num_slices-1:0] w_sl_gt;
    logic [c_num_slices-1:0] w_sl_eq;

    generate
        for (genvar gi = 0; gi < c_num_slices; gi++) begin : g_slice
            cmp_slice u_slice (
                .i_a  (w_a_ext[gi*c_slice_w +: c_slice_w]),
                .i_b  (w_b_ext[gi*c_slice_w +: c_slice_w]),
                .o_gt (w_sl_gt[gi]),
                .o_eq (w_sl_eq[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // MSB-first priority combine: the most significant slice that differs
    // alone decides gt; if every slice is equal the operands are equal.
    // ------------------------------------------------------------------------
    logic w_gt;
    logic w_found;
    logic w_eq;
    res_e w_res;

    always_comb begin
        w_gt    = 1'b0;
        w_found = 1'b0;
        for (int i = c_num_slices - 1; i >= 0; i--) begin
            if (!w_found && !w_sl_eq[i]) begin
                w_gt    = w_sl_gt[i];
                w_found = 1'b1;
            end
        end
    end

    assign w_eq  = ~w_found;
    assign w_res = classify(w_gt, w_eq);

    // ------------------------------------------------------------------------
    // Result register and valid pulse
    // Results only load on a valid cycle so they hold otherwise. Reset
    // clears the valid flag asynchronously, which discards any result that
    // was about to be presented.
    // ------------------------------------------------------------------------
    logic r_gt;
    logic r_lt;
    logic r_eq;
    logic r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_gt <= (w_res == RES_GT);
                r_lt <= (w_res == RES_LT);
                r_eq <= (w_res == RES_EQ);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result counters
    // They update on the same edge as the result register, so the new count
    // is visible in the cycle out_valid is high. A clear takes priority over
    // a coincident valid result, which is then not counted.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt_cnt <= '0;
            r_lt_cnt <= '0;
            r_eq_cnt <= '0;
        end else if (cnt_clr) begin
            r_gt_cnt <= '0;
            r_lt_cnt <= '0;
            r_eq_cnt <= '0;
        end else if (in_valid) begin
            case (w_res)
                RES_GT:  r_gt_cnt <= sat_inc(r_gt_cnt);
                RES_LT:  r_lt_cnt <= sat_inc(r_lt_cnt);
                RES_EQ:  r_eq_cnt <= sat_inc(r_eq_cnt);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign out_valid = r_valid;
    assign gt_cnt    = r_gt_cnt;
    assign lt_cnt    = r_lt_cnt;
    assign eq_cnt    = r_eq_cnt;

endmodule : cmp
`default_nettype wire

// File: tb/tb_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp
//  Description : Self-checking bench for cmp. Main instance uses WIDTH=8,
//                CNT_W=4 (so saturation is reachable); a second instance
//                with WIDTH=6 exercises the zero-extended partial slice.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] a6;
    logic [5:0] b6;
    logic       in_valid;
    logic       signed_en;
    logic       cnt_clr;

    logic       gt, lt, eq, out_valid;
    logic [3:0] gt_cnt, lt_cnt, eq_cnt;

    logic        gt6, lt6, eq6, out_valid6;
    logic [15:0] gt_cnt6, lt_cnt6, eq_cnt6;

    int vectors;
    int miscompares;

    cmp #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .signed_en (signed_en),
        .cnt_clr   (cnt_clr),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .out_valid (out_valid),
        .gt_cnt    (gt_cnt),
        .lt_cnt    (lt_cnt),
        .eq_cnt    (eq_cnt)
    );

    cmp #(.WIDTH(6), .CNT_W(16)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a6),
        .b         (b6),
        .in_valid  (in_valid),
        .signed_en (signed_en),
        .cnt_clr   (cnt_clr),
        .gt        (gt6),
        .lt        (lt6),
        .eq        (eq6),
        .out_valid (out_valid6),
        .gt_cnt    (gt_cnt6),
        .lt_cnt    (lt_cnt6),
        .eq_cnt    (eq_cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (just after a rising edge), then step to
    // 1 time unit after the next rising edge, where results are sampled.
    task automatic apply(input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic tv, input logic tc);
        a         = ta;
        b         = tb;
        signed_en = ts;
        in_valid  = tv;
        cnt_clr   = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic eg, input logic el,
                           input logic ee, input logic ev);
        chk({tag, ".gt"}, gt, eg);
        chk({tag, ".lt"}, lt, el);
        chk({tag, ".eq"}, eq, ee);
        chk({tag, ".out_valid"}, out_valid, ev);
    endtask

    task automatic chk_cnt(input string tag, input int eg, input int el, input int ee);
        chk({tag, ".gt_cnt"}, gt_cnt, 64'(eg));
        chk({tag, ".lt_cnt"}, lt_cnt, 64'(el));
        chk({tag, ".eq_cnt"}, eq_cnt, 64'(ee));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [5:0] ra6, rb6;
        logic       rs;
        logic       xg, xl, xe, xg6, xl6, xe6;
        int         m_gt, m_lt, m_eq;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        a           = '0;
        b           = '0;
        a6          = '0;
        b6          = '0;
        in_valid    = 1'b0;
        signed_en   = 1'b0;
        cnt_clr     = 1'b0;

        // ---- reset state ----
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_res("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0, 0);
        rst_n = 1'b1;

        // ---- basic unsigned ----
        apply(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
        chk_res("u00_01", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_cnt("u00_01", 0, 1, 0);
        apply(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        chk_res("u01_00", 1'b1, 1'b0, 1'b0, 1'b1);
        apply(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        chk_res("u01_01", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cnt("u01_01", 1, 1, 1);

        // ---- idle: results hold, no pulse, counts unchanged ----
        apply(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk_res("idle", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("idle", 1, 1, 1);

        // ---- signed vs unsigned ----
        apply(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        chk_res("s80_01", 1'b0, 1'b1, 1'b0, 1'b1);
        apply(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        chk_res("u80_01", 1'b1, 1'b0, 1'b0, 1'b1);
        apply(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk_res("sFF_FF", 1'b0, 1'b0, 1'b1, 1'b1);
        apply(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        chk_res("uFF_FF", 1'b0, 1'b0, 1'b1, 1'b1);
        apply(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk_res("s7F_FF", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("signed", 3, 2, 3);

        // ---- saturation: 20 equal pairs back-to-back ----
        for (int i = 0; i < 20; i++) begin
            apply(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
        end
        chk_res("sat", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cnt("sat", 3, 2, 15);

        // ---- clear coinciding with a valid result: clear wins ----
        apply(8'h05, 8'h05, 1'b0, 1'b1, 1'b1);
        chk_res("clr_vld", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cnt("clr_vld", 0, 0, 0);

        // ---- mid-stream asynchronous reset ----
        apply(8'h02, 8'h01, 1'b0, 1'b1, 1'b0);
        chk_res("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("pre_rst", 1, 0, 0);
        a        = 8'h03;
        b        = 8'h07;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_res("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        chk_res("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk_res("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("post_rst", 0, 0, 0);

        // ---- first valid after reset processed normally ----
        apply(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        chk_res("first", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_cnt("first", 0, 1, 0);

        // ---- standalone clear ----
        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_res("clr_only", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt("clr_only", 0, 0, 0);

        // ---- WIDTH=6 directed: sign bit is bit 5 ----
        a6 = 6'h20;
        b6 = 6'h01;
        apply(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("w6_s20_01.lt", lt6, 1'b1);
        a6 = 6'h20;
        b6 = 6'h01;
        apply(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("w6_u20_01.gt", gt6, 1'b1);

        // ---- random back-to-back stream against a reference model ----
        m_gt = 0;
        m_lt = 0;
        m_eq = 0;
        for (int n = 0; n < 1000; n++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            ra6 = 6'($urandom);
            rb6 = ($urandom_range(0, 7) == 0) ? ra6 : 6'($urandom);
            rs  = 1'($urandom);
            a6  = ra6;
            b6  = rb6;
            apply(ra, rb, rs, 1'b1, 1'b0);

            if (rs) begin
                xg  = $signed(ra) > $signed(rb);
                xl  = $signed(ra) < $signed(rb);
                xg6 = $signed(ra6) > $signed(rb6);
                xl6 = $signed(ra6) < $signed(rb6);
            end else begin
                xg  = ra > rb;
                xl  = ra < rb;
                xg6 = ra6 > rb6;
                xl6 = ra6 < rb6;
            end
            xe  = (ra == rb);
            xe6 = (ra6 == rb6);
            if (xg && m_gt < 15) m_gt++;
            if (xl && m_lt < 15) m_lt++;
            if (xe && m_eq < 15) m_eq++;

            chk_res("rand", xg, xl, xe, 1'b1);
            chk("rand.onehot", 64'($countones({gt, lt, eq})), 64'd1);
            chk_cnt("rand", m_gt, m_lt, m_eq);
            chk("rand6.gt", gt6, xg6);
            chk("rand6.lt", lt6, xl6);
            chk("rand6.eq", eq6, xe6);
        end

        apply(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("end.out_valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cmp
`default_nettype wire
